// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences one shift-register byte exchange (load, timed shifts, capture)
// behind a Start/Busy/Done handshake.
`timescale 1ns/1ps

module shift_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Abort,
    input  logic [7:0] TxData,
    input  logic [7:0] RegData,
    output logic       Load,
    output logic       Shift,
    output logic [7:0] LoadIn,
    output logic [7:0] RxData,
    output logic       Busy,
    output logic       Done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_BIT     = 2'd2,
        S_CAPTURE = 2'd3
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [DIV_W-1:0]   div_q;
    logic               load_q;
    logic               shift_q;
    logic               busy_q;
    logic               done_q;
    logic [7:0]         load_in_q;
    logic [7:0]         rx_q;

    logic               div_last;
    logic               div_pre_last;
    logic               bit_last;

    // Divider/bit-counter terminal decodes; pre_last lets Shift be registered a cycle early
    assign div_last     = (div_q == DIV_W'(DIV - 1));
    assign div_pre_last = (({1'b0, div_q} + (DIV_W + 1)'(1)) == (DIV_W + 1)'(DIV - 1));
    assign bit_last     = (bit_cnt_q == CNT_W'(WIDTH - 1));

    // Sequencer FSM with all strobes and handshake outputs registered
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            div_q     <= '0;
            load_q    <= 1'b0;
            shift_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            load_in_q <= 8'h00;
            rx_q      <= 8'h00;
        end else begin
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            done_q  <= 1'b0;
            if ((state_q != S_IDLE) && Abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (Start) begin
                            load_in_q <= TxData;
                            load_q    <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        bit_cnt_q <= '0;
                        div_q     <= '0;
                        shift_q   <= (DIV == 1);
                        state_q   <= S_BIT;
                    end
                    S_BIT: begin
                        if (div_last) begin
                            div_q     <= '0;
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            if (bit_last) begin
                                state_q <= S_CAPTURE;
                            end else begin
                                shift_q <= (DIV == 1);
                            end
                        end else begin
                            div_q   <= div_q + DIV_W'(1);
                            shift_q <= div_pre_last;
                        end
                    end
                    S_CAPTURE: begin
                        rx_q    <= RegData;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign Load   = load_q;
    assign Shift  = shift_q;
    assign LoadIn = load_in_q;
    assign RxData = rx_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: two instances (DIV=4 and DIV=1) each driving a bench-side
// shift register; a scoreboard queue holds expected transfers, a monitor checks them.
`timescale 1ns/1ps

module tb_shift_sequencer;

    localparam int unsigned WIDTH = 8;

    typedef struct {
        int         t0;
        logic [7:0] tx;
        logic [7:0] ser;
        int         abort_at;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start    [2];
    logic       abort    [2];
    logic [7:0] tx_data  [2];
    logic [7:0] reg_data [2];
    logic       load     [2];
    logic       shift    [2];
    logic       busy     [2];
    logic       done     [2];
    logic [7:0] load_in  [2];
    logic [7:0] rx_data  [2];
    logic       ser_in   [2];

    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    exp_t       sb_q [2][$];
    logic [7:0] last_rx [2];

    int         nshift   [2];
    int         busy_cnt [2];
    logic       loaded   [2];
    logic       prev_busy[2];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int div_of(input int g);
        return (g == 0) ? 4 : 1;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned DV = (g == 0) ? 4 : 1;
        shift_sequencer #(.WIDTH(WIDTH), .DIV(DV)) u_dut (
            .Clk    (clk),
            .Reset  (rst_n),
            .Start  (start[g]),
            .Abort  (abort[g]),
            .TxData (tx_data[g]),
            .RegData(reg_data[g]),
            .Load   (load[g]),
            .Shift  (shift[g]),
            .LoadIn (load_in[g]),
            .RxData (rx_data[g]),
            .Busy   (busy[g]),
            .Done   (done[g])
        );
    end

    // Bench-side shift register datapath, MSB out first, serial in at bit 0
    always @(posedge clk or negedge rst_n) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) reg_data[g] <= 8'h00;
            else if (load[g]) reg_data[g] <= load_in[g];
            else if (shift[g]) reg_data[g] <= {reg_data[g][6:0], ser_in[g]};
        end
    end

    // Monitor: compares every strobe and completion against the scoreboard head
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            exp_t h;
            logic have;
            int   dv;
            dv = div_of(g);
            if (!rst_n) begin
                nshift[g] = 0; busy_cnt[g] = 0; loaded[g] = 1'b0; prev_busy[g] = 1'b0;
            end else begin
                have = (sb_q[g].size() > 0);
                if (have) h = sb_q[g][0];
                if (busy[g]) busy_cnt[g]++;
                if (load[g] && shift[g]) check("load_shift_overlap", 32'(1), 32'(0));
                if (load[g]) begin
                    if (!have || loaded[g]) check("unexpected_load", 32'(1), 32'(0));
                    else begin
                        check("load_cycle", 32'(cyc - h.t0), 32'(1));
                        check("load_in", 32'(load_in[g]), 32'(h.tx));
                        check("busy_at_load", 32'(busy[g]), 32'(1));
                    end
                    loaded[g] = 1'b1;
                end
                if (shift[g]) begin
                    if (!have || !loaded[g] || nshift[g] >= 8) check("unexpected_shift", 32'(1), 32'(0));
                    else begin
                        check("shift_cycle", 32'(cyc - h.t0), 32'(1 + dv * (nshift[g] + 1)));
                        check("reg_out_bit", 32'(reg_data[g][7]), 32'(h.tx[7 - nshift[g]]));
                        ser_in[g] = h.ser[7 - nshift[g]];
                    end
                    nshift[g]++;
                end
                if (done[g]) begin
                    if (!have) check("unexpected_done", 32'(1), 32'(0));
                    else begin
                        check("done_cycle", 32'(cyc - h.t0), 32'(3 + dv * 8));
                        check("rx_data", 32'(rx_data[g]), 32'(h.ser));
                        check("shift_count", 32'(nshift[g]), 32'(8));
                        check("busy_cycles", 32'(busy_cnt[g]), 32'(dv * 8 + 2));
                        check("done_not_aborted", 32'(h.abort_at), 32'(0));
                        last_rx[g] = h.ser;
                        void'(sb_q[g].pop_front());
                    end
                    nshift[g] = 0; busy_cnt[g] = 0; loaded[g] = 1'b0;
                end else if (prev_busy[g] && !busy[g]) begin
                    if (!have) check("unexpected_busy_fall", 32'(1), 32'(0));
                    else begin
                        check("abort_expected", 32'(h.abort_at != 0), 32'(1));
                        check("abort_cycle", 32'(cyc - h.t0), 32'(h.abort_at + 1));
                        check("rx_hold", 32'(rx_data[g]), 32'(last_rx[g]));
                        void'(sb_q[g].pop_front());
                    end
                    nshift[g] = 0; busy_cnt[g] = 0; loaded[g] = 1'b0;
                end
                prev_busy[g] = busy[g];
            end
        end
    end

    task automatic issue(input int g, input logic [7:0] txv, input logic [7:0] serv, input int abort_at);
        exp_t e;
        e.t0 = cyc; e.tx = txv; e.ser = serv; e.abort_at = abort_at;
        sb_q[g].push_back(e);
        start[g]   = 1'b1;
        tx_data[g] = txv;
        @(negedge clk);
        start[g]   = 1'b0;
        tx_data[g] = 8'($urandom);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        while ((sb_q[g].size() > 0 || busy[g]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 200), 32'(1));
        @(negedge clk);
    endtask

    task automatic check_zero(input int g, input string tag);
        check({tag, "_load"},    32'(load[g]),    32'(0));
        check({tag, "_shift"},   32'(shift[g]),   32'(0));
        check({tag, "_busy"},    32'(busy[g]),    32'(0));
        check({tag, "_done"},    32'(done[g]),    32'(0));
        check({tag, "_load_in"}, 32'(load_in[g]), 32'(0));
        check({tag, "_rx"},      32'(rx_data[g]), 32'(0));
    endtask

    initial begin
        int t0;
        int n;
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0; abort[g] = 1'b0; tx_data[g] = 8'h00; last_rx[g] = 8'h00;
        end
        #2;
        check_zero(0, "reset0");
        check_zero(1, "reset1");
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_zero(0, "idle0");
        check_zero(1, "idle1");

        // Default transfer, serial input tied high
        issue(0, 8'hA5, 8'hFF, 0);
        wait_idle(0);

        // DIV=1 transfer, then a new Start accepted in the Done cycle
        issue(1, 8'h3C, 8'h00, 0);
        n = 0;
        while (!done[1] && n < 100) begin @(negedge clk); n++; end
        check("div1_done_seen", 32'(done[1]), 32'(1));
        issue(1, 8'($urandom), 8'($urandom), 0);
        wait_idle(1);

        // Start pulsed again mid-transfer is ignored
        t0 = cyc;
        issue(0, 8'($urandom), 8'($urandom), 0);
        wait_cyc(t0 + 10);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_idle(0);

        // Abort in IDLE alongside Start is ignored
        abort[0] = 1'b1;
        issue(0, 8'($urandom), 8'($urandom), 0);
        abort[0] = 1'b0;
        wait_idle(0);

        // Abort after three shifts, then a full transfer
        t0 = cyc;
        issue(0, 8'($urandom), 8'($urandom), 14);
        wait_cyc(t0 + 14);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        wait_idle(0);
        issue(0, 8'($urandom), 8'($urandom), 0);
        wait_idle(0);

        // Reset mid-transfer takes effect without a clock
        t0 = cyc;
        issue(0, 8'($urandom), 8'($urandom), 0);
        wait_cyc(t0 + 20);
        rst_n = 1'b0;
        #1;
        check_zero(0, "midreset");
        sb_q[0].delete();
        last_rx[0] = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 8'h01, 8'($urandom), 0);
        wait_idle(0);

        // Randomized transfers on both instances
        for (int i = 0; i < 10; i++) begin
            int g;
            g = int'($urandom_range(1, 0));
            issue(g, 8'($urandom), 8'($urandom), 0);
            wait_idle(g);
        end

        check("sb0_empty", 32'(sb_q[0].size()), 32'(0));
        check("sb1_empty", 32'(sb_q[1].size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
